// File: rtl/hyper_cmd_seq_if.sv
// Bundle of the splitter handshake, PHY word channel, uDMA data paths and
// completion flag around the HyperBus command sequencer. Signal suffixes are
// relative to the sequencer.
interface hyper_cmd_seq_if #(
  parameter int ID_WIDTH   = 1,
  parameter int TRANS_SIZE = 16
);
  logic                  trans_valid_i;
  logic                  trans_ready_o;
  logic [31:0]           hyper_addr_i;
  logic [TRANS_SIZE-1:0] size_i;
  logic                  rw_i;
  logic                  addr_space_i;
  logic                  burst_type_i;
  logic [15:0]           intreg_i;
  logic [ID_WIDTH:0]     trans_id_i;
  logic [4:0]            t_latency_access_i;
  logic                  en_latency_additional_i;
  logic [31:0]           t_read_write_recovery_i;
  logic                  phy_valid_o;
  logic                  phy_ready_i;
  logic [15:0]           phy_data_o;
  logic [1:0]            phy_type_o;
  logic                  cs_n_o;
  logic                  tx_valid_i;
  logic                  tx_ready_o;
  logic [15:0]           tx_data_i;
  logic                  phy_rx_valid_i;
  logic [15:0]           phy_rx_data_i;
  logic                  rx_valid_o;
  logic [15:0]           rx_data_o;
  logic                  done_o;
  logic [ID_WIDTH:0]     done_id_o;

  // Surrounding logic: splitter, PHY and uDMA
  modport master (
    output trans_valid_i, hyper_addr_i, size_i, rw_i, addr_space_i,
           burst_type_i, intreg_i, trans_id_i, t_latency_access_i,
           en_latency_additional_i, t_read_write_recovery_i, phy_ready_i,
           tx_valid_i, tx_data_i, phy_rx_valid_i, phy_rx_data_i,
    input  trans_ready_o, phy_valid_o, phy_data_o, phy_type_o, cs_n_o,
           tx_ready_o, rx_valid_o, rx_data_o, done_o, done_id_o
  );

  // The sequencer itself
  modport slave (
    input  trans_valid_i, hyper_addr_i, size_i, rw_i, addr_space_i,
           burst_type_i, intreg_i, trans_id_i, t_latency_access_i,
           en_latency_additional_i, t_read_write_recovery_i, phy_ready_i,
           tx_valid_i, tx_data_i, phy_rx_valid_i, phy_rx_data_i,
    output trans_ready_o, phy_valid_o, phy_data_o, phy_type_o, cs_n_o,
           tx_ready_o, rx_valid_o, rx_data_o, done_o, done_id_o
  );
endinterface

// File: rtl/hyper_cmd_seq.sv
// HyperBus per-sub-transaction command sequencer: CA word issue, latency
// wait, data phase, read/write recovery and tagged completion pulse.
module hyper_cmd_seq #(
  parameter int ID_WIDTH   = 1,
  parameter int TRANS_SIZE = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  hyper_cmd_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CA0, S_CA1, S_CA2, S_LAT, S_WDATA, S_RDATA, S_RECOV
  } state_t;

  state_t                r_state, w_next;
  logic [47:0]           r_ca;
  logic                  r_rw;
  logic                  r_regw;
  logic [15:0]           r_intreg;
  logic [ID_WIDTH:0]     r_id;
  logic [5:0]            r_lat;
  logic [TRANS_SIZE-1:0] r_cnt;
  logic [31:0]           r_rec;
  logic                  r_done;

  logic                  w_phy_valid;
  logic [15:0]           w_phy_data;
  logic [1:0]            w_phy_type;
  logic                  w_tx_ready;
  logic [TRANS_SIZE-1:0] w_size_p1;
  logic [TRANS_SIZE-1:0] w_words;
  logic [5:0]            w_lat_init;
  logic                  w_unused;

  assign w_size_p1  = bus.size_i + TRANS_SIZE'(1);
  assign w_words    = w_size_p1 >> 1;
  assign w_lat_init = bus.en_latency_additional_i ? {bus.t_latency_access_i, 1'b0}
                                                  : {1'b0, bus.t_latency_access_i};
  assign w_unused   = bus.hyper_addr_i[0];

  // Next-state and PHY/uDMA handshake outputs
  always_comb begin
    w_next      = r_state;
    w_phy_valid = 1'b0;
    w_phy_data  = '0;
    w_phy_type  = 2'd0;
    w_tx_ready  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.trans_valid_i) w_next = S_CA0;
      S_CA0: begin
        w_phy_valid = 1'b1;
        w_phy_data  = r_ca[47:32];
        if (bus.phy_ready_i) w_next = S_CA1;
      end
      S_CA1: begin
        w_phy_valid = 1'b1;
        w_phy_data  = r_ca[31:16];
        if (bus.phy_ready_i) w_next = S_CA2;
      end
      S_CA2: begin
        w_phy_valid = 1'b1;
        w_phy_data  = r_ca[15:0];
        if (bus.phy_ready_i) begin
          // Register writes carry no latency and no word count; L=0 skips LAT
          if (r_regw)               w_next = S_WDATA;
          else if (r_cnt == '0)     w_next = S_RECOV;
          else if (r_lat == 6'd0)   w_next = r_rw ? S_RDATA : S_WDATA;
          else                      w_next = S_LAT;
        end
      end
      S_LAT: if (r_lat <= 6'd1) w_next = r_rw ? S_RDATA : S_WDATA;
      S_WDATA: begin
        w_phy_type = 2'd1;
        if (r_regw) begin
          w_phy_valid = 1'b1;
          w_phy_data  = r_intreg;
          if (bus.phy_ready_i) w_next = S_RECOV;
        end else begin
          w_phy_valid = bus.tx_valid_i;
          w_tx_ready  = bus.phy_ready_i;
          w_phy_data  = bus.tx_data_i;
          if (bus.tx_valid_i && bus.phy_ready_i && r_cnt <= TRANS_SIZE'(1))
            w_next = S_RECOV;
        end
      end
      S_RDATA: if (bus.phy_rx_valid_i && r_cnt <= TRANS_SIZE'(1)) w_next = S_RECOV;
      S_RECOV: if (r_rec <= 32'd1) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register, accept-time capture and the saturating down-counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_ca     <= '0;
      r_rw     <= 1'b0;
      r_regw   <= 1'b0;
      r_intreg <= '0;
      r_id     <= {1'b1, {ID_WIDTH{1'b0}}};
      r_lat    <= '0;
      r_cnt    <= '0;
      r_rec    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_RECOV) && (r_state != S_RECOV);
      case (r_state)
        S_IDLE: if (bus.trans_valid_i) begin
          r_ca     <= {bus.rw_i, bus.addr_space_i, bus.burst_type_i, 1'b0,
                       bus.hyper_addr_i[31:4], 13'd0, bus.hyper_addr_i[3:1]};
          r_rw     <= bus.rw_i;
          r_regw   <= bus.addr_space_i && !bus.rw_i;
          r_intreg <= bus.intreg_i;
          r_id     <= bus.trans_id_i;
          r_lat    <= w_lat_init;
          r_cnt    <= w_words;
          r_rec    <= bus.t_read_write_recovery_i;
        end
        S_LAT: if (r_lat != 6'd0) r_lat <= r_lat - 6'd1;
        S_WDATA:
          if (!r_regw && bus.tx_valid_i && bus.phy_ready_i && r_cnt != '0)
            r_cnt <= r_cnt - TRANS_SIZE'(1);
        S_RDATA:
          if (bus.phy_rx_valid_i && r_cnt != '0) r_cnt <= r_cnt - TRANS_SIZE'(1);
        S_RECOV: if (r_rec != 32'd0) r_rec <= r_rec - 32'd1;
        default: ;
      endcase
    end
  end

  assign bus.trans_ready_o = (r_state == S_IDLE) && !rst_i;
  assign bus.phy_valid_o   = w_phy_valid;
  assign bus.phy_data_o    = w_phy_data;
  assign bus.phy_type_o    = w_phy_type;
  assign bus.tx_ready_o    = w_tx_ready;
  assign bus.cs_n_o        = (r_state == S_IDLE) || (r_state == S_RECOV);
  assign bus.rx_valid_o    = (r_state == S_RDATA) && bus.phy_rx_valid_i;
  assign bus.rx_data_o     = bus.phy_rx_data_i;
  assign bus.done_o        = r_done;
  assign bus.done_id_o     = r_id;

endmodule

// File: tb/tb_hyper_cmd_seq.sv
// Directed self-checking bench for hyper_cmd_seq.
module tb_hyper_cmd_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hyper_cmd_seq_if #(.ID_WIDTH(1), .TRANS_SIZE(16)) bus ();

  hyper_cmd_seq #(.ID_WIDTH(1), .TRANS_SIZE(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int c;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_trans(input logic [31:0] addr, input logic [15:0] size,
                           input logic rw, input logic space, input logic burst,
                           input logic [15:0] intreg, input logic [1:0] id,
                           input logic [4:0] lat, input logic add, input logic [31:0] rec);
    bus.hyper_addr_i            = addr;
    bus.size_i                  = size;
    bus.rw_i                    = rw;
    bus.addr_space_i            = space;
    bus.burst_type_i            = burst;
    bus.intreg_i                = intreg;
    bus.trans_id_i              = id;
    bus.t_latency_access_i      = lat;
    bus.en_latency_additional_i = add;
    bus.t_read_write_recovery_i = rec;
    bus.trans_valid_i           = 1'b1;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (bus.done_o !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_ready(input int budget, output int cyc);
    cyc = 0;
    while (bus.trans_ready_o !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_trans('0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    bus.trans_valid_i  = 1'b0;
    bus.phy_ready_i    = 1'b1;
    bus.tx_valid_i     = 1'b0;
    bus.tx_data_i      = '0;
    bus.phy_rx_valid_i = 1'b0;
    bus.phy_rx_data_i  = '0;
    tick();
    tick();

    // Reset values
    chk("rst_trans_ready", bus.trans_ready_o, 0);
    chk("rst_cs_n", bus.cs_n_o, 1);
    chk("rst_phy_valid", bus.phy_valid_o, 0);
    chk("rst_phy_data", bus.phy_data_o, 0);
    chk("rst_phy_type", bus.phy_type_o, 0);
    chk("rst_tx_ready", bus.tx_ready_o, 0);
    chk("rst_rx_valid", bus.rx_valid_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_done_id", bus.done_id_o, 2);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", bus.trans_ready_o, 1);

    // Memory read: 4 words, L = 12, recovery 3
    set_trans(32'h0000_1234, 16'd8, 1'b1, 1'b0, 1'b1, 16'h0, 2'd1, 5'd6, 1'b1, 32'd3);
    bus.phy_rx_valid_i = 1'b1;
    bus.phy_rx_data_i  = 16'hD000;
    tick();
    bus.trans_valid_i = 1'b0;
    #1;
    chk("rd_ca0", bus.phy_data_o, 16'hA000);
    chk("rd_ca0_valid", bus.phy_valid_o, 1);
    chk("rd_ca0_type", bus.phy_type_o, 0);
    chk("rd_cs_n", bus.cs_n_o, 0);
    chk("rd_busy_ready", bus.trans_ready_o, 0);
    tick();
    chk("rd_ca1", bus.phy_data_o, 16'h0123);
    tick();
    chk("rd_ca2", bus.phy_data_o, 16'h0002);
    tick();
    c = 0;
    while (bus.rx_valid_o !== 1'b1 && c < 40) begin
      c++;
      tick();
    end
    chk("rd_lat_cycles", c, 12);
    chk("rd_rx0", bus.rx_data_o, 16'hD000);
    tick();
    bus.phy_rx_valid_i = 1'b0;
    #1;
    chk("rd_gap", bus.rx_valid_o, 0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      bus.phy_rx_valid_i = 1'b1;
      bus.phy_rx_data_i  = 16'hD000 + 16'(k);
      #1;
      chk("rd_rxk_valid", bus.rx_valid_o, 1);
      chk("rd_rxk_data", bus.rx_data_o, 16'hD000 + 64'(k));
      tick();
    end
    chk("rd_done", bus.done_o, 1);
    chk("rd_done_id", bus.done_id_o, 1);
    chk("rd_recov_cs_n", bus.cs_n_o, 1);
    chk("rd_excess_rx", bus.rx_valid_o, 0);
    tick();
    chk("rd_done_pulse", bus.done_o, 0);
    bus.phy_rx_valid_i = 1'b0;
    wait_ready(20, c);
    chk("rd_recov_rest", c, 2);

    // Register write: one WDATA word of intreg, no LAT, tx_ready stays low
    set_trans(32'h0, 16'd4, 1'b0, 1'b1, 1'b1, 16'h8F1F, 2'd2, 5'd6, 1'b1, 32'd0);
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = 16'h5555;
    tick();
    bus.trans_valid_i = 1'b0;
    #1;
    chk("rw_ca0", bus.phy_data_o, 16'h6000);
    chk("rw_ca0_txr", bus.tx_ready_o, 0);
    tick();
    tick();
    tick();
    chk("rw_wdata", bus.phy_data_o, 16'h8F1F);
    chk("rw_wtype", bus.phy_type_o, 1);
    chk("rw_wvalid", bus.phy_valid_o, 1);
    chk("rw_wtxr", bus.tx_ready_o, 0);
    tick();
    chk("rw_done", bus.done_o, 1);
    chk("rw_done_id", bus.done_id_o, 2);
    chk("rw_recov_valid", bus.phy_valid_o, 0);
    wait_ready(20, c);
    chk("rw_recov", c, 1);
    bus.tx_valid_i = 1'b0;

    // Memory write, size 5 -> 3 words, CA1 backpressure, toggling tx_valid
    set_trans(32'h0000_0010, 16'd5, 1'b0, 1'b0, 1'b0, 16'h0, 2'd3, 5'd1, 1'b0, 32'd1);
    tick();
    bus.trans_valid_i = 1'b0;
    #1;
    chk("mw_ca0", bus.phy_data_o, 16'h0000);
    tick();
    bus.phy_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ca1_hold", bus.phy_data_o, 16'h0001);
      chk("bp_ca1_valid", bus.phy_valid_o, 1);
      tick();
    end
    bus.phy_ready_i = 1'b1;
    #1;
    chk("bp_ca1_still", bus.phy_data_o, 16'h0001);
    tick();
    chk("mw_ca2_type", bus.phy_type_o, 0);
    chk("mw_ca2_valid", bus.phy_valid_o, 1);
    tick();
    chk("mw_lat_valid", bus.phy_valid_o, 0);
    tick();
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = 16'h1111;
    #1;
    chk("mw_w1_valid", bus.phy_valid_o, 1);
    chk("mw_w1_txr", bus.tx_ready_o, 1);
    chk("mw_w1_data", bus.phy_data_o, 16'h1111);
    chk("mw_w1_type", bus.phy_type_o, 1);
    tick();
    bus.tx_valid_i = 1'b0;
    #1;
    chk("mw_gap_valid", bus.phy_valid_o, 0);
    tick();
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = 16'h2222;
    #1;
    chk("mw_w2_data", bus.phy_data_o, 16'h2222);
    tick();
    bus.tx_valid_i = 1'b0;
    tick();
    bus.tx_valid_i  = 1'b1;
    bus.tx_data_i   = 16'h3333;
    bus.phy_ready_i = 1'b0;
    #1;
    chk("mw_stall_txr", bus.tx_ready_o, 0);
    chk("mw_stall_valid", bus.phy_valid_o, 1);
    tick();
    bus.phy_ready_i = 1'b1;
    #1;
    chk("mw_no_early_done", bus.done_o, 0);
    chk("mw_w3_data", bus.phy_data_o, 16'h3333);
    tick();
    bus.tx_valid_i = 1'b0;
    chk("mw_done", bus.done_o, 1);
    chk("mw_done_id", bus.done_id_o, 3);
    wait_ready(20, c);
    chk("mw_recov", c, 1);

    // Back-to-back zero-size reads; second request held during the first
    set_trans(32'h0, 16'd0, 1'b1, 1'b0, 1'b0, 16'h0, 2'd0, 5'd3, 1'b0, 32'd6);
    tick();
    bus.trans_id_i              = 2'd1;
    bus.t_read_write_recovery_i = 32'd2;
    #1;
    chk("b2b_busy", bus.trans_ready_o, 0);
    wait_done(20, c);
    chk("b2b_min_latency", c + 1, 4);
    chk("b2b_id0", bus.done_id_o, 0);
    wait_ready(40, c);
    chk("b2b_recov6", c, 6);
    tick();
    bus.trans_valid_i = 1'b0;
    wait_done(20, c);
    chk("b2b_lat2", c, 3);
    chk("b2b_id1", bus.done_id_o, 1);
    wait_ready(20, c);
    chk("b2b_recov2", c, 2);

    // Reset in RDATA with 2 words still outstanding, L = 0
    set_trans(32'h0, 16'd8, 1'b1, 1'b0, 1'b0, 16'h0, 2'd1, 5'd0, 1'b0, 32'd5);
    tick();
    bus.trans_valid_i = 1'b0;
    tick();
    tick();
    tick();
    bus.phy_rx_valid_i = 1'b1;
    bus.phy_rx_data_i  = 16'hAAAA;
    #1;
    chk("ra_nolat_rx", bus.rx_valid_o, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("ra_cs_n", bus.cs_n_o, 1);
    chk("ra_phy_valid", bus.phy_valid_o, 0);
    chk("ra_rx_valid", bus.rx_valid_o, 0);
    chk("ra_done", bus.done_o, 0);
    chk("ra_done_id", bus.done_id_o, 2);
    chk("ra_trans_ready", bus.trans_ready_o, 0);
    chk("ra_tx_ready", bus.tx_ready_o, 0);
    rst = 1'b0;
    bus.phy_rx_valid_i = 1'b0;
    #1;
    chk("ra_ready_after", bus.trans_ready_o, 1);
    tick();
    chk("ra_no_late_done", bus.done_o, 0);
    set_trans(32'h0, 16'd0, 1'b0, 1'b0, 1'b0, 16'h0, 2'd3, 5'd0, 1'b0, 32'd1);
    tick();
    bus.trans_valid_i = 1'b0;
    wait_done(20, c);
    chk("ra_new_lat", c, 3);
    chk("ra_new_id", bus.done_id_o, 3);
    wait_ready(20, c);
    chk("ra_new_recov", c, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
